// File: rtl/spi_dds_ctrl.sv
// SPI slave (mode 0, MSB first) that writes the DDS phase increment and the LED register,
// and reads the phase increment back on MISO. All logic runs in the clk domain.
module spi_dds_ctrl #(
  parameter int                CMD_W       = 8,
  parameter int                DATA_W      = 48,
  parameter logic [DATA_W-1:0] DEFAULT_INC = 48'h218DEF41
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              SCK,
  input  logic              MOSI,
  input  logic              SSEL,
  output logic              MISO,
  output logic [DATA_W-1:0] dds_data,
  output logic              dds_we,
  output logic [7:0]        led,
  output logic              frame_err
);

  localparam int               FRAME_W    = CMD_W + DATA_W;
  localparam logic [6:0]       FRAME_BITS = 7'(FRAME_W);
  localparam logic [6:0]       FRAME_LAST = 7'(FRAME_W - 1);
  localparam logic [6:0]       CMD_LAST   = 7'(CMD_W - 1);
  localparam logic [CMD_W-1:0] CMD_WR_INC = CMD_W'(1);
  localparam logic [CMD_W-1:0] CMD_RD_INC = CMD_W'(2);
  localparam logic [CMD_W-1:0] CMD_WR_LED = CMD_W'(3);

  typedef enum logic [1:0] {IDLE, CMD, DATA, WAIT_END} state_t;

  state_t              r_state, w_next;
  logic [2:0]          r_sck_sync, r_ssel_sync;
  logic [1:0]          r_mosi_sync;
  logic [1:0]          r_fill;
  logic                r_armed;
  logic [6:0]          r_cnt;
  logic [FRAME_W-1:0]  r_rx;
  logic [CMD_W-1:0]    r_cmd;
  logic [DATA_W-1:0]   r_tx;
  logic                r_tx_pend, r_miso_en;
  logic [DATA_W-1:0]   r_dds_data;
  logic                r_dds_we, r_frame_err;
  logic [7:0]          r_led;

  logic                w_sck_rise, w_sck_fall, w_ssel_rise, w_ssel_fall, w_mosi;
  logic                w_start, w_end, w_frame_ok;
  logic [CMD_W-1:0]    w_frame_cmd;
  logic [DATA_W-1:0]   w_frame_data;

  assign w_sck_rise   =  r_sck_sync[1]  & ~r_sck_sync[2];
  assign w_sck_fall   = ~r_sck_sync[1]  &  r_sck_sync[2];
  assign w_ssel_rise  =  r_ssel_sync[1] & ~r_ssel_sync[2];
  assign w_ssel_fall  = ~r_ssel_sync[1] &  r_ssel_sync[2];
  assign w_mosi       =  r_mosi_sync[1];
  // The synchronizer resets to SSEL=1, so a chip select already low at reset release
  // would look like a fresh falling edge; r_armed blocks that until SSEL is seen high.
  assign w_start      = w_ssel_fall & r_armed & (r_state == IDLE);
  assign w_end        = w_ssel_rise & (r_state != IDLE);
  assign w_frame_ok   = (r_cnt == FRAME_BITS);
  assign w_frame_cmd  = r_rx[FRAME_W-1 -: CMD_W];
  assign w_frame_data = r_rx[DATA_W-1:0];

  assign MISO      = r_miso_en & r_tx[DATA_W-1];
  assign dds_data  = r_dds_data;
  assign dds_we    = r_dds_we;
  assign led       = r_led;
  assign frame_err = r_frame_err;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (w_start) w_next = CMD;
      CMD:      if (w_sck_rise && r_cnt == CMD_LAST) w_next = DATA;
      DATA:     if (w_sck_rise && r_cnt == FRAME_LAST) w_next = WAIT_END;
      default:  w_next = r_state;
    endcase
    if (w_ssel_rise) w_next = IDLE;
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_sck_sync  <= 3'b000;
      r_ssel_sync <= 3'b111;
      r_mosi_sync <= 2'b00;
      r_fill      <= '0;
      r_armed     <= 1'b0;
      r_cnt       <= '0;
      r_rx        <= '0;
      r_cmd       <= '0;
      r_tx        <= '0;
      r_tx_pend   <= 1'b0;
      r_miso_en   <= 1'b0;
      r_dds_data  <= DEFAULT_INC;
      r_dds_we    <= 1'b0;
      r_led       <= 8'h01;
      r_frame_err <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[1:0], SCK};
      r_ssel_sync <= {r_ssel_sync[1:0], SSEL};
      r_mosi_sync <= {r_mosi_sync[0], MOSI};
      r_dds_we    <= 1'b0;
      r_frame_err <= 1'b0;
      if (r_fill != 2'd3) r_fill <= r_fill + 2'd1;
      if (r_fill == 2'd3 && r_ssel_sync[1]) r_armed <= 1'b1;

      if (w_start) begin
        r_cnt     <= '0;
        r_rx      <= '0;
        r_cmd     <= '0;
        r_tx      <= '0;
        r_tx_pend <= 1'b0;
        r_miso_en <= 1'b0;
      end else if (r_state != IDLE && w_sck_rise) begin
        if (r_cnt != 7'd127) r_cnt <= r_cnt + 7'd1;
        r_rx <= {r_rx[FRAME_W-2:0], w_mosi};
        if (r_state == CMD && r_cnt == CMD_LAST) begin
          r_cmd     <= {r_rx[CMD_W-2:0], w_mosi};
          r_tx_pend <= 1'b1;
        end
      end

      // First falling edge of the data phase snapshots dds_data; later edges shift it out.
      if ((r_state == DATA || r_state == WAIT_END) && w_sck_fall && r_cmd == CMD_RD_INC) begin
        if (r_tx_pend) begin
          r_tx      <= r_dds_data;
          r_tx_pend <= 1'b0;
          r_miso_en <= 1'b1;
        end else begin
          r_tx <= {r_tx[DATA_W-2:0], 1'b0};
        end
      end

      if (w_end) begin
        r_miso_en <= 1'b0;
        r_tx_pend <= 1'b0;
        if (w_frame_ok && w_frame_cmd == CMD_WR_INC) begin
          r_dds_data <= w_frame_data;
          r_dds_we   <= 1'b1;
        end else if (w_frame_ok && w_frame_cmd == CMD_WR_LED) begin
          r_led <= w_frame_data[7:0];
        end else if (!(w_frame_ok && w_frame_cmd == CMD_RD_INC)) begin
          r_frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_dds_ctrl.sv
// Directed bench for spi_dds_ctrl: SPI mode-0 master at SCK = clk/8 with hand-computed results.
module tb_spi_dds_ctrl;

  localparam logic [47:0] DEF_INC = 48'h0000218DEF41;

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic        SCK = 1'b0;
  logic        MOSI = 1'b0;
  logic        SSEL = 1'b1;
  logic        MISO;
  logic [47:0] dds_data;
  logic        dds_we;
  logic [7:0]  led;
  logic        frame_err;

  int n_checks = 0;
  int n_errors = 0;
  int we_cnt   = 0;
  int err_cnt  = 0;

  spi_dds_ctrl #(
    .CMD_W(8),
    .DATA_W(48),
    .DEFAULT_INC(48'h218DEF41)
  ) dut (
    .clk(clk),
    .RESET(RESET),
    .SCK(SCK),
    .MOSI(MOSI),
    .SSEL(SSEL),
    .MISO(MISO),
    .dds_data(dds_data),
    .dds_we(dds_we),
    .led(led),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dds_we)    we_cnt++;
    if (frame_err) err_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic spi_bit(input logic b, output logic m);
    MOSI = b;
    repeat (4) @(negedge clk);
    m = MISO;
    SCK = 1'b1;
    repeat (4) @(negedge clk);
    SCK = 1'b0;
  endtask

  task automatic spi_frame(input logic [63:0] bits, input int n, output logic [63:0] mi);
    logic m;
    SSEL = 1'b0;
    mi = '0;
    for (int i = 0; i < n; i++) begin
      spi_bit(bits[n-1-i], m);
      mi = {mi[62:0], m};
    end
  endtask

  // Bit k of each pattern is the strobe value k+1 cycles after SSEL is raised.
  task automatic end_frame(output logic [7:0] we_pat, output logic [7:0] err_pat);
    repeat (4) @(negedge clk);
    SSEL = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      we_pat[k]  = dds_we;
      err_pat[k] = frame_err;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (5) @(negedge clk);
    n_checks++; if (dds_data !== DEF_INC) begin n_errors++; $display("FAIL rst_dds_data: got %h required %h", dds_data, DEF_INC); end
    n_checks++; if (led !== 8'h01) begin n_errors++; $display("FAIL rst_led: got %h required 01", led); end
    n_checks++; if (dds_we !== 1'b0) begin n_errors++; $display("FAIL rst_dds_we: got %b required 0", dds_we); end
    n_checks++; if (frame_err !== 1'b0) begin n_errors++; $display("FAIL rst_frame_err: got %b required 0", frame_err); end
    n_checks++; if (MISO !== 1'b0) begin n_errors++; $display("FAIL rst_miso: got %b required 0", MISO); end
    RESET = 1'b0;
    repeat (30) @(negedge clk);
    n_checks++; if (dds_data !== DEF_INC) begin n_errors++; $display("FAIL idle_dds_data: got %h required %h", dds_data, DEF_INC); end
    n_checks++; if (led !== 8'h01) begin n_errors++; $display("FAIL idle_led: got %h required 01", led); end
    n_checks++; if (we_cnt !== 0) begin n_errors++; $display("FAIL idle_we_count: got %0d required 0", we_cnt); end
    n_checks++; if (err_cnt !== 0) begin n_errors++; $display("FAIL idle_err_count: got %0d required 0", err_cnt); end
  endtask

  task automatic test_write_inc();
    logic [63:0] mi;
    logic [7:0]  wp, ep;
    spi_frame({8'h00, 8'h01, 48'h123456789ABC}, 56, mi);
    end_frame(wp, ep);
    n_checks++; if (wp !== 8'b0000_0100) begin n_errors++; $display("FAIL wr_we_timing: got %b required 00000100", wp); end
    n_checks++; if (ep !== 8'h00) begin n_errors++; $display("FAIL wr_frame_err: got %b required 00000000", ep); end
    n_checks++; if (dds_data !== 48'h123456789ABC) begin n_errors++; $display("FAIL wr_dds_data: got %h required 123456789abc", dds_data); end
    n_checks++; if (led !== 8'h01) begin n_errors++; $display("FAIL wr_led: got %h required 01", led); end
    n_checks++; if (mi[55:0] !== 56'h0) begin n_errors++; $display("FAIL wr_miso_quiet: got %h required 0", mi[55:0]); end
  endtask

  task automatic test_read_inc();
    logic [63:0] mi;
    logic [7:0]  wp, ep;
    int          we_before;
    we_before = we_cnt;
    spi_frame({8'h00, 8'h02, 48'h000000000000}, 56, mi);
    end_frame(wp, ep);
    n_checks++; if (mi[55:0] !== 56'h00123456789ABC) begin n_errors++; $display("FAIL rd_miso_stream: got %h required 00123456789abc", mi[55:0]); end
    n_checks++; if (we_cnt !== we_before) begin n_errors++; $display("FAIL rd_no_we: got %0d required %0d", we_cnt, we_before); end
    n_checks++; if (ep !== 8'h00) begin n_errors++; $display("FAIL rd_frame_err: got %b required 00000000", ep); end
    n_checks++; if (dds_data !== 48'h123456789ABC) begin n_errors++; $display("FAIL rd_dds_data: got %h required 123456789abc", dds_data); end
    n_checks++; if (led !== 8'h01) begin n_errors++; $display("FAIL rd_led: got %h required 01", led); end
    n_checks++; if (MISO !== 1'b0) begin n_errors++; $display("FAIL rd_miso_idle: got %b required 0", MISO); end
  endtask

  task automatic test_write_led();
    logic [63:0] mi;
    logic [7:0]  wp, ep;
    spi_frame({8'h00, 8'h03, 48'h0000000000A5}, 56, mi);
    end_frame(wp, ep);
    n_checks++; if (led !== 8'hA5) begin n_errors++; $display("FAIL led_value: got %h required a5", led); end
    n_checks++; if (dds_data !== 48'h123456789ABC) begin n_errors++; $display("FAIL led_dds_data: got %h required 123456789abc", dds_data); end
    n_checks++; if (wp !== 8'h00) begin n_errors++; $display("FAIL led_no_we: got %b required 00000000", wp); end
    n_checks++; if (ep !== 8'h00) begin n_errors++; $display("FAIL led_frame_err: got %b required 00000000", ep); end
  endtask

  task automatic test_bad_frames();
    logic [63:0] vec  [3];
    int          nbit [3];
    logic [63:0] mi;
    logic [7:0]  wp, ep;
    vec[0] = 64'h0000_0001_FFFF_0000; nbit[0] = 40;  // first 40 bits of an 8'h01 frame
    vec[1] = {7'h00, 8'h01, 48'hDEADBEEF0123, 1'b1}; nbit[1] = 57;
    vec[2] = {8'h00, 8'h7F, 48'h111111111111}; nbit[2] = 56;
    for (int t = 0; t < 3; t++) begin
      spi_frame(vec[t], nbit[t], mi);
      end_frame(wp, ep);
      n_checks++; if (ep !== 8'b0000_0100) begin n_errors++; $display("FAIL bad%0d_err_pulse: got %b required 00000100", t, ep); end
      n_checks++; if (wp !== 8'h00) begin n_errors++; $display("FAIL bad%0d_no_we: got %b required 00000000", t, wp); end
      n_checks++; if (dds_data !== 48'h123456789ABC) begin n_errors++; $display("FAIL bad%0d_dds_data: got %h required 123456789abc", t, dds_data); end
      n_checks++; if (led !== 8'hA5) begin n_errors++; $display("FAIL bad%0d_led: got %h required a5", t, led); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [55:0] word;
    logic [63:0] mi;
    logic [7:0]  wp, ep;
    logic        m;
    int          we_before, err_before;
    word = {8'h01, 48'hCAFEF00DBEEF};
    SSEL = 1'b0;
    for (int i = 0; i < 30; i++) spi_bit(word[55-i], m);
    RESET = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (dds_data !== DEF_INC) begin n_errors++; $display("FAIL mid_rst_dds_data: got %h required %h", dds_data, DEF_INC); end
    n_checks++; if (led !== 8'h01) begin n_errors++; $display("FAIL mid_rst_led: got %h required 01", led); end
    RESET = 1'b0;
    we_before  = we_cnt;
    err_before = err_cnt;
    for (int i = 30; i < 56; i++) spi_bit(word[55-i], m);
    end_frame(wp, ep);
    n_checks++; if (we_cnt !== we_before) begin n_errors++; $display("FAIL mid_no_we: got %0d required %0d", we_cnt, we_before); end
    n_checks++; if (err_cnt !== err_before) begin n_errors++; $display("FAIL mid_no_err: got %0d required %0d", err_cnt, err_before); end
    n_checks++; if (dds_data !== DEF_INC) begin n_errors++; $display("FAIL mid_dds_data: got %h required %h", dds_data, DEF_INC); end
    spi_frame({8'h00, 8'h01, 48'h00000ABCDEF0}, 56, mi);
    end_frame(wp, ep);
    n_checks++; if (wp !== 8'b0000_0100) begin n_errors++; $display("FAIL post_we_timing: got %b required 00000100", wp); end
    n_checks++; if (dds_data !== 48'h00000ABCDEF0) begin n_errors++; $display("FAIL post_dds_data: got %h required 00000abcdef0", dds_data); end
    n_checks++; if (ep !== 8'h00) begin n_errors++; $display("FAIL post_frame_err: got %b required 00000000", ep); end
  endtask

  initial begin
    test_reset();
    test_write_inc();
    test_read_inc();
    test_write_led();
    test_bad_frames();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
